// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared memory-system widths and block-transfer controller state encoding
package mem_ctrl_pkg;
  localparam int PA_WIDTH = 32;
  localparam int BLK_WIDTH = 512;
  localparam int BYTE = 8;
  localparam int WRD_WIDTH = 32;
  localparam int BLK_BYTES = BLK_WIDTH / BYTE;
  localparam int OFFSET_BITS = $clog2(BLK_BYTES);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_ctrl_state_t;
endpackage

// File: rtl/mem_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else if (inc && !(&count_q)) count_q <= count_q + W'(1);
  assign count = count_q;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: one-at-a-time block read/write sequencer with fixed access latency
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4,
  parameter int STAT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [PA_WIDTH-1:0]  req_addr,
  input  logic [BLK_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_we,
  output logic [BLK_WIDTH-1:0] resp_rdata,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_data,
  input  logic [BLK_WIDTH-1:0] mem_rd_data,
  output logic [STAT_W-1:0]    rd_count,
  output logic [STAT_W-1:0]    wr_count
);
  localparam int CNT_W = $clog2(16);
  localparam logic [PA_WIDTH-1:0] ALIGN_MASK = ~((PA_WIDTH'(1) << OFFSET_BITS) - PA_WIDTH'(1));
  if (RD_LAT < 1 || RD_LAT > 15 || WR_LAT < 1 || WR_LAT > 15) begin : g_bad_lat
    $error("mem_ctrl: RD_LAT and WR_LAT must lie in 1..15");
  end
  mem_ctrl_state_t      state_q;
  logic [CNT_W-1:0]     cnt_q, lat;
  logic                 we_q, resp_we_q, rd_en_q, wr_en_q, rd_en_d, wr_en_d, accept, fire, we_n, resp_hs;
  logic [PA_WIDTH-1:0]  addr_q;
  logic [BLK_WIDTH-1:0] wdata_q, rdata_q;
  assign accept  = req_valid && state_q == IDLE;
  assign resp_hs = state_q == RESP && resp_ready;
  assign lat     = req_we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
  // strobe is registered, so it is raised on the edge where cnt moves to 1
  always_comb begin
    fire    = accept ? lat == CNT_W'(1) : (state_q == ACCESS && cnt_q == CNT_W'(2));
    we_n    = accept ? req_we : we_q;
    rd_en_d = fire && !we_n;
    wr_en_d = fire && we_n;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      resp_we_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= ACCESS;
          we_q    <= req_we;
          addr_q  <= req_addr & ALIGN_MASK;
          wdata_q <= req_wdata;
          cnt_q   <= lat;
        end
        ACCESS: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= RESP;
            resp_we_q <= we_q;
            rdata_q   <= we_q ? '0 : mem_rd_data;
          end
        end
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready   = state_q == IDLE;
  assign resp_valid  = state_q == RESP;
  assign resp_we     = resp_we_q;
  assign resp_rdata  = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wdata_q;
  sat_counter #(.W(STAT_W)) u_rd_cnt (.clk(clk), .rst(rst), .inc(resp_hs && !resp_we_q), .count(rd_count));
  sat_counter #(.W(STAT_W)) u_wr_cnt (.clk(clk), .rst(rst), .inc(resp_hs && resp_we_q), .count(wr_count));
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a block-level memory model
module tb_mem_ctrl;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;
  localparam int STAT_W = 2;
  localparam int CMAX = (1 << STAT_W) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_we, mem_rd_en, mem_wr_en;
  logic [511:0] resp_rdata, mem_wr_data, mem_rd_data;
  logic [31:0] mem_addr;
  logic [STAT_W-1:0] rd_count, wr_count;
  logic [511:0] mem [16];
  logic [511:0] ref_mem [16];
  int n_chk = 0, n_err = 0, exp_rc = 0, exp_wc = 0;

  mem_ctrl #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_we(resp_we), .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .rd_count(rd_count), .wr_count(wr_count));

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr[9:6]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[9:6]] <= mem_wr_data;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_we", resp_we, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [511:0] wd, input int hold);
    int lat;
    logic [3:0] blk;
    logic [31:0] aligned;
    logic [511:0] exp_data;
    lat = we ? WR_LAT : RD_LAT;
    blk = addr[9:6];
    aligned = {addr[31:6], 6'b0};
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; resp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0; req_wdata = ~wd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("rd_en", mem_rd_en, !we && k == lat);
      chk("wr_en", mem_wr_en, we && k == lat);
      chk("resp_valid_early", resp_valid, 0);
      chk("req_ready_busy", req_ready, 0);
      chk("mem_addr", mem_addr, aligned);
      if (we) chk("mem_wr_data", mem_wr_data, wd);
    end
    exp_data = we ? '0 : ref_mem[blk];
    if (we) ref_mem[blk] = wd;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("resp_valid", resp_valid, 1);
      chk("resp_we", resp_we, we);
      chk("resp_rdata", resp_rdata, exp_data);
      chk("req_ready_resp", req_ready, 0);
      chk("strobe_idle", {mem_rd_en, mem_wr_en}, 0);
      chk("mem_addr_hold", mem_addr, aligned);
      if (h == hold) resp_ready = 1'b1;
      else if (h == 0) begin
        req_valid = 1'b1; req_we = ~we; req_addr = 32'h100;
      end
    end
    if (we) exp_wc = exp_wc < CMAX ? exp_wc + 1 : CMAX;
    else exp_rc = exp_rc < CMAX ? exp_rc + 1 : CMAX;
    @(negedge clk);
    chk("resp_valid_clr", resp_valid, 0);
    chk("req_ready_after", req_ready, 1);
    chk("rd_count", rd_count, exp_rc);
    chk("wr_count", wr_count, exp_wc);
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = rnd_blk();
      ref_mem[i] = mem[i];
    end
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h000, '0, 0);
    xact(1'b1, 32'h040, {64{8'hA5}}, 0);
    xact(1'b0, 32'h040, '0, 0);
    chk("a5_block", ref_mem[1], {64{8'hA5}});
    xact(1'b0, 32'h047, '0, 0);
    xact(1'b0, 32'h080, '0, 5);
    xact(1'b1, 32'h0c4, rnd_blk(), 3);
    // reset lands in the first access cycle of a write, before its strobe edge
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0c0; req_wdata = ~ref_mem[3]; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_wr", mem_wr_en, 0);
    end
    rst = 1'b0;
    exp_rc = 0; exp_wc = 0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_wr", mem_wr_en, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    chk("mem_unchanged", mem[3], ref_mem[3]);
    chk("post_rst_rd_count", rd_count, 0);
    for (int i = 0; i < 5; i++) xact(1'b0, 32'(i * 64), '0, 0);
    chk("rd_saturated", rd_count, 3);
    for (int i = 0; i < 25; i++)
      xact(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), rnd_blk(), int'($urandom_range(0, 3)));
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
